delay_eye_calibrator: RTL and testbench
=======================================

// Module: delay_eye_calibrator
// PURPOSE
//  Sequences a 9-bit cascaded IDELAY/ODELAY tap pair to find and centre the data eye.
//  - Sweeps taps 0..TAP_MAX. At each tap: load the tap, settle, then sample a per-cycle pass flag.
//  - Records the longest run of passing taps and parks the delay at the centre of that run.
//  - Also accepts a manual tap load when idle.
//  - Sits between the link training logic and the delay pair's load/value inputs.
// PARAMETERS
//  SETTLE_CYCLES  16   cycles waited after each delay_load before sampling (>=1)
//  SAMPLE_LOG2    6    log2 of pass-flag samples taken per tap (64 cycles)
//  TAP_MAX        511  last tap swept (<=511)
//  MIN_EYE        8    minimum passing-run width for success
// PORTS
//  clk           in   1   clock; delay pair also runs on clk
//  reset_n       in   1   asynchronous, active-low reset
//  start         in   1   begin sweep; sampled only in IDLE
//  manual_valid  in   1   load manual_value; sampled only in IDLE, start has priority
//  manual_value  in   9   tap for manual load
//  sample_ok     in   1   1 = data captured this cycle matched training pattern
//  delay_load    out  1   one-cycle load strobe to delay pair
//  delay__value  out  9   tap value to delay pair; held between loads
//  busy          out  1   high in every state except IDLE
//  done          out  1   one-cycle pulse when sweep or manual load completes
//  fail          out  1   sweep found no eye >= MIN_EYE; held until next start
//  eye_start     out  9   first tap of best eye (valid from done)
//  eye_width     out  10  width of best eye in taps, 0..512
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE. reset_n low mid-sweep aborts immediately; no load issued.
//  States: IDLE, LOAD, SETTLE, SAMPLE, EVAL, APPLY, APPLY_SETTLE, FINISH.
//  IDLE, start=1:
//   - Save delay__value as prev_tap. Set tap=0, clear run and best registers, clear fail.
//   - Go to LOAD.
//  IDLE, manual_valid=1 (start=0):
//   - delay__value<=manual_value, go to APPLY. eye_* and fail unchanged.
//  LOAD (1 cycle):
//   - delay_load=1 with delay__value=tap in the same cycle. Go to SETTLE.
//  SETTLE: exactly SETTLE_CYCLES cycles, then SAMPLE.
//  SAMPLE: exactly 2^SAMPLE_LOG2 cycles. tap_good = AND of sample_ok over these cycles.
//  EVAL (1 cycle):
//   - If tap_good: run_len++, run_start=tap when run_len was 0.
//     Then if new run_len > best_width (strict), best<=run. Earliest longest eye wins.
//   - If not tap_good: run_len<=0.
//   - If tap==TAP_MAX go to APPLY, else tap++ and go to LOAD.
//  APPLY entry from sweep:
//   - If best_width>=MIN_EYE: delay__value<=best_start+(best_width>>1), eye_start/eye_width<=best.
//   - Else: fail<=1, delay__value<=prev_tap, eye_start/eye_width<=best (may be 0).
//  APPLY (1 cycle): delay_load=1. Then APPLY_SETTLE for SETTLE_CYCLES cycles, then FINISH.
//  FINISH (1 cycle): done=1, then IDLE. busy falls in the same cycle IDLE is entered.
//  Widths:
//   - run_len/best_width are 10 bits; all 512 taps passing gives width 512.
//   - Centre start+(width>>1) <= 511, so no 9-bit overflow. No wrap of tap past TAP_MAX.
//  Boundaries:
//   - A run ending at TAP_MAX counts. Equal-width later runs do not replace best.
//   - start/manual_valid while busy are ignored, not queued.
//   - delay_load is never asserted in two consecutive cycles.
//  Per-tap latency: 1+SETTLE_CYCLES+2^SAMPLE_LOG2+1 cycles.
//  Sweep total: (TAP_MAX+1)*per-tap + SETTLE_CYCLES + 2 cycles.
// STRUCTURE
//  delay_cal_pkg:
//   - Constant TAP_BITS=9.
//   - State enum delay_cal_state_t.
//   - Typedef eye_t {start[8:0], width[9:0]}.
//  Sub-module delay_cal_timer:
//   - Loadable down-counter with zero flag.
//   - Shared by SETTLE, SAMPLE and APPLY_SETTLE.
// TESTING (bench: TAP_MAX=31, SETTLE_CYCLES=4, SAMPLE_LOG2=2, MIN_EYE=3)
//  1 Reset:
//   - reset_n low mid-SAMPLE -> all outputs 0 next edge.
//   - Release -> IDLE, no delay_load.
//  2 Clean eye:
//   - sample_ok=1 only for taps 10..19 -> eye_start=10, eye_width=10, final value 15.
//   - done pulses once; fail=0.
//  3 Two equal eyes:
//   - Taps 2..5 and 20..23 pass -> eye_start=2, eye_width=4, final 4.
//  4 No eye:
//   - prev value 7; only taps 3..4 pass -> fail=1, eye_width=2, final delay__value=7.
//   - delay_load pulses once in APPLY.
//  5 Edge cases:
//   - All taps pass -> eye_start=0, eye_width=32, final 16.
//   - Single failing sample mid-SAMPLE marks that tap bad.
//  6 Manual load:
//   - manual_value=100 in IDLE -> one delay_load, done after SETTLE+2 cycles.
//   - start while busy is ignored; sweep length unchanged.

Source files
------------

// File: rtl/delay_cal_pkg.sv
// Shared types and constants for the delay eye calibrator: tap width, FSM states, eye record.
package delay_cal_pkg;

  localparam int unsigned TAP_BITS = 9;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StSample,
    StEval,
    StApply,
    StApplySettle,
    StFinish
  } delay_cal_state_t;

  typedef struct packed {
    logic [TAP_BITS-1:0] start;
    logic [TAP_BITS:0]   width;
  } eye_t;

endpackage

// File: rtl/delay_eye_calibrator_if.sv
// Link-training side and delay-pair side signals of the eye calibrator, grouped as one bundle.
interface delay_eye_calibrator_if import delay_cal_pkg::*; ();

  logic                start;
  logic                manual_valid;
  logic [TAP_BITS-1:0] manual_value;
  logic                sample_ok;
  logic                delay_load;
  logic [TAP_BITS-1:0] delay__value;
  logic                busy;
  logic                done;
  logic                fail;
  logic [TAP_BITS-1:0] eye_start;
  logic [TAP_BITS:0]   eye_width;

  modport master (
    output start, manual_valid, manual_value, sample_ok,
    input  delay_load, delay__value, busy, done, fail, eye_start, eye_width
  );

  modport slave (
    input  start, manual_valid, manual_value, sample_ok,
    output delay_load, delay__value, busy, done, fail, eye_start, eye_width
  );

endinterface

// File: rtl/delay_cal_timer.sv
// Loadable down-counter with zero flag; reused for settle, sample and apply-settle windows.
module delay_cal_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/delay_eye_calibrator.sv
// Sweeps the delay tap pair, tracks the longest passing run and parks the tap at its centre.
module delay_eye_calibrator import delay_cal_pkg::*; #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SAMPLE_LOG2   = 6,
  parameter int unsigned TAP_MAX       = 511,
  parameter int unsigned MIN_EYE       = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  delay_eye_calibrator_if.slave  bus
);

  localparam int unsigned SampleCycles = 1 << SAMPLE_LOG2;
  localparam int unsigned TmrMax  = (SETTLE_CYCLES > SampleCycles) ? SETTLE_CYCLES : SampleCycles;
  localparam int unsigned TmrW    = (TmrMax > 1) ? $clog2(TmrMax) : 1;
  localparam logic [TmrW-1:0]       SettleLd = TmrW'(SETTLE_CYCLES - 1);
  localparam logic [TmrW-1:0]       SampleLd = TmrW'(SampleCycles - 1);
  localparam logic [TAP_BITS-1:0]   TapMax   = TAP_BITS'(TAP_MAX);
  localparam logic [TAP_BITS:0]     MinEye   = (TAP_BITS + 1)'(MIN_EYE);

  delay_cal_state_t    state_d, state_q;
  logic [TAP_BITS-1:0] tap_d, tap_q;
  logic [TAP_BITS-1:0] prev_tap_d, prev_tap_q;
  logic [TAP_BITS:0]   run_len_d, run_len_q;
  logic [TAP_BITS-1:0] run_start_d, run_start_q;
  eye_t                best_d, best_q;
  eye_t                eye_d, eye_q;
  logic                good_d, good_q;
  logic [TAP_BITS-1:0] delay_value_d, delay_value_q;
  logic                delay_load_d, delay_load_q;
  logic                busy_d, busy_q;
  logic                done_d, done_q;
  logic                fail_d, fail_q;

  logic                tmr_load, tmr_zero;
  logic [TmrW-1:0]     tmr_value;
  logic [TAP_BITS:0]   run_len_new;
  logic [TAP_BITS-1:0] run_start_new;
  eye_t                best_new;
  logic [TAP_BITS:0]   centre;

  delay_cal_timer #(
    .Width (TmrW)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .zero_o  (tmr_zero)
  );

  always_comb begin
    state_d       = state_q;
    tap_d         = tap_q;
    prev_tap_d    = prev_tap_q;
    run_len_d     = run_len_q;
    run_start_d   = run_start_q;
    best_d        = best_q;
    eye_d         = eye_q;
    good_d        = good_q;
    delay_value_d = delay_value_q;
    fail_d        = fail_q;
    delay_load_d  = 1'b0;
    done_d        = 1'b0;
    tmr_load      = 1'b0;
    tmr_value     = '0;

    // Run bookkeeping for the tap just sampled; only committed in StEval.
    run_len_new   = good_q ? run_len_q + 1'b1 : '0;
    run_start_new = (good_q && run_len_q == '0) ? tap_q : run_start_q;
    best_new      = best_q;
    if (good_q && run_len_new > best_q.width) begin
      best_new.start = run_start_new;
      best_new.width = run_len_new;
    end
    centre = {1'b0, best_new.start} + (best_new.width >> 1);

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          prev_tap_d    = delay_value_q;
          tap_d         = '0;
          run_len_d     = '0;
          run_start_d   = '0;
          best_d        = '0;
          fail_d        = 1'b0;
          delay_value_d = '0;
          delay_load_d  = 1'b1;
          state_d       = StLoad;
        end else if (bus.manual_valid) begin
          delay_value_d = bus.manual_value;
          delay_load_d  = 1'b1;
          state_d       = StApply;
        end
      end
      StLoad: begin
        tmr_load  = 1'b1;
        tmr_value = SettleLd;
        good_d    = 1'b1;
        state_d   = StSettle;
      end
      StSettle: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = SampleLd;
          state_d   = StSample;
        end
      end
      StSample: begin
        good_d = good_q & bus.sample_ok;
        if (tmr_zero) state_d = StEval;
      end
      StEval: begin
        run_len_d    = run_len_new;
        run_start_d  = run_start_new;
        best_d       = best_new;
        delay_load_d = 1'b1;
        if (tap_q == TapMax) begin
          eye_d = best_new;
          if (best_new.width >= MinEye) begin
            delay_value_d = centre[TAP_BITS-1:0];
          end else begin
            fail_d        = 1'b1;
            delay_value_d = prev_tap_q;
          end
          state_d = StApply;
        end else begin
          tap_d         = tap_q + 1'b1;
          delay_value_d = tap_q + 1'b1;
          state_d       = StLoad;
        end
      end
      StApply: begin
        tmr_load  = 1'b1;
        tmr_value = SettleLd;
        state_d   = StApplySettle;
      end
      StApplySettle: begin
        if (tmr_zero) begin
          done_d  = 1'b1;
          state_d = StFinish;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      tap_q         <= '0;
      prev_tap_q    <= '0;
      run_len_q     <= '0;
      run_start_q   <= '0;
      best_q        <= '0;
      eye_q         <= '0;
      good_q        <= 1'b0;
      delay_value_q <= '0;
      delay_load_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tap_q         <= tap_d;
      prev_tap_q    <= prev_tap_d;
      run_len_q     <= run_len_d;
      run_start_q   <= run_start_d;
      best_q        <= best_d;
      eye_q         <= eye_d;
      good_q        <= good_d;
      delay_value_q <= delay_value_d;
      delay_load_q  <= delay_load_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
    end
  end

  assign bus.delay_load   = delay_load_q;
  assign bus.delay__value = delay_value_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.fail         = fail_q;
  assign bus.eye_start    = eye_q.start;
  assign bus.eye_width    = eye_q.width;

endmodule

// File: tb/tb_delay_eye_calibrator.sv
// Scoreboard bench: stimulus queues expected eye results, a monitor checks them on each done.
module tb_delay_eye_calibrator;

  localparam int S     = 4;
  localparam int SLOG  = 2;
  localparam int TMAX  = 31;
  localparam int MINE  = 3;
  localparam int NTAP  = TMAX + 1;
  localparam int SWEEP_LAT = NTAP * (1 + S + (1 << SLOG) + 1) + S + 2;
  localparam int MAN_LAT   = S + 2;

  typedef struct {
    int es, ew, fl, val, issue, lat, loads;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  delay_eye_calibrator_if bus ();

  delay_eye_calibrator #(
    .SETTLE_CYCLES (S),
    .SAMPLE_LOG2   (SLOG),
    .TAP_MAX       (TMAX),
    .MIN_EYE       (MINE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  // Reference state: what the calibrator should be holding after the last transaction.
  int m_es = 0, m_ew = 0, m_fl = 0, m_val = 0;

  // Sample-pass pattern driven for the current sweep.
  logic [31:0] pass_mask = '0;
  logic        glitch_en = 1'b0;
  int          glitch_tap = 0;
  int          glitch_off = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // sample_ok follows the mask only inside the sample window; garbage elsewhere must be ignored.
  initial begin
    int off = 100;
    int cur = 0;
    bus.sample_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.delay_load) begin
        off = 0;
        cur = int'(bus.delay__value);
      end else if (off < 1000) begin
        off++;
      end
      if (off >= 1 + S && off <= S + (1 << SLOG)) begin
        bus.sample_ok = (cur < NTAP) && pass_mask[cur] &&
                        !(glitch_en && cur == glitch_tap && off == glitch_off);
      end else begin
        bus.sample_ok = 1'($urandom % 2);
      end
    end
  end

  // Monitor: pops one expectation per done pulse.
  initial begin
    int   loads = 0;
    logic prev_load = 1'b0;
    logic prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        loads = 0;
        prev_load = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (prev_load) chk("load_not_back_to_back", 32'(bus.delay_load), 0);
        if (bus.delay_load) loads++;
        if (prev_done) chk("done_then_idle", {30'd0, bus.done, bus.busy}, 0);
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("eye_start", 32'(bus.eye_start), e.es);
            chk("eye_width", 32'(bus.eye_width), e.ew);
            chk("fail", 32'(bus.fail), e.fl);
            chk("final_value", 32'(bus.delay__value), e.val);
            chk("busy_at_done", 32'(bus.busy), 1);
            chk("latency", cyc - e.issue, e.lat);
            chk("load_count", loads, e.loads);
          end
          loads = 0;
        end
        prev_load = bus.delay_load;
        prev_done = bus.done;
      end
    end
  end

  function automatic logic [31:0] span(input int a, input int b);
    logic [31:0] m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Best eye = earliest maximal run of ones; centre or previous tap on failure.
  task automatic model_sweep(input logic [31:0] eff);
    int bs = 0;
    int bw = 0;
    for (int s = 0; s < NTAP; s++) begin
      if (eff[s] && (s == 0 || !eff[s-1])) begin
        int len = 0;
        while (s + len < NTAP && eff[s+len]) len++;
        if (len > bw) begin
          bw = len;
          bs = s;
        end
      end
    end
    m_es = bs;
    m_ew = bw;
    m_fl = (bw < MINE) ? 1 : 0;
    if (!m_fl) m_val = bs + bw / 2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("idle_timeout", 32'(bus.busy), 0);
  endtask

  task automatic sweep(input logic [31:0] mask, input logic ge, input int gtap, input logic poke);
    exp_t        e;
    logic [31:0] eff;
    wait_idle();
    @(negedge clk);
    pass_mask  = mask;
    glitch_en  = ge;
    glitch_tap = gtap;
    glitch_off = $urandom_range(S + (1 << SLOG), S + 1);
    eff = mask;
    if (ge) eff[gtap] = 1'b0;
    model_sweep(eff);
    e = '{es: m_es, ew: m_ew, fl: m_fl, val: m_val, issue: cyc, lat: SWEEP_LAT, loads: NTAP + 1};
    exp_q.push_back(e);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (poke) begin
      repeat (40 + $urandom_range(100)) @(negedge clk);
      bus.start = 1'b1;
      bus.manual_valid = 1'b1;
      bus.manual_value = 9'($urandom);
      @(negedge clk);
      bus.start = 1'b0;
      bus.manual_valid = 1'b0;
    end
    wait_idle();
  endtask

  task automatic manual(input int v);
    exp_t e;
    wait_idle();
    @(negedge clk);
    m_val = v;
    e = '{es: m_es, ew: m_ew, fl: m_fl, val: m_val, issue: cyc, lat: MAN_LAT, loads: 1};
    exp_q.push_back(e);
    bus.manual_valid = 1'b1;
    bus.manual_value = 9'(v);
    @(negedge clk);
    bus.manual_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rm;
    int          gt;
    bus.start = 1'b0;
    bus.manual_valid = 1'b0;
    bus.manual_value = '0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.delay_load, bus.delay__value, bus.busy, bus.done, bus.fail,
                          bus.eye_start, bus.eye_width}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {30'd0, bus.busy, bus.delay_load}, 0);

    // Abort a sweep while sampling tap 2.
    pass_mask = '1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (25) @(negedge clk);
    chk("mid_sweep_busy", 32'(bus.busy), 1);
    chk("mid_sweep_tap", 32'(bus.delay__value), 2);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_outputs", {bus.delay_load, bus.delay__value, bus.busy, bus.done, bus.fail,
                          bus.eye_start, bus.eye_width}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_abort_quiet", {30'd0, bus.busy, bus.delay_load}, 0);
    end

    sweep(span(10, 19), 1'b0, 0, 1'b1);
    sweep(span(2, 5) | span(20, 23), 1'b0, 0, 1'b0);
    manual(7);
    sweep(span(3, 4), 1'b0, 0, 1'b0);
    sweep('1, 1'b0, 0, 1'b1);
    sweep(span(10, 19), 1'b1, 12, 1'b0);
    sweep(span(25, 31) | span(1, 6), 1'b0, 0, 1'b0);
    manual(100);
    for (int k = 0; k < 4; k++) begin
      rm = $urandom | ($urandom & $urandom);
      gt = $urandom_range(TMAX);
      sweep(rm, rm[gt], gt, 1'($urandom % 2));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
